uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop rx synchroniser, mid-bit sampling FSM,
// optional parity, 1-2 checked stop bits, receive FIFO and sticky error flags.
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 900,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          Rst,
  input  logic                          rx,
  input  logic                          en,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          brk,
  output logic                          busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state;
  logic                   rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]          cnt;
  logic [3:0]             bit_idx;
  logic                   stop_idx;
  logic                   stop_bad;
  logic                   par_bad;
  logic [DATA_BITS-1:0]   shreg;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;

  logic tick, stop_now_bad, frame_end, push_req, fe_evt, brk_evt, pe_evt;
  logic pop, full, do_push, ov_evt;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_comb begin
    tick         = (cnt == '0);
    stop_now_bad = stop_bad | ~rx_sync;
    frame_end    = en && (state == STOP) && tick && (stop_idx == LAST_STOP);
    push_req     = frame_end & ~stop_now_bad;
    fe_evt       = frame_end & stop_now_bad;
    brk_evt      = fe_evt & (shreg == '0);
    pe_evt       = frame_end & par_bad;
    dout_valid   = (fifo_count != '0);
    pop          = dout_valid & dout_ready;
    full         = (fifo_count == FULL_CNT);
    do_push      = push_req & (~full | pop);
    ov_evt       = push_req & full & ~pop;
    // Gate the head with valid so an empty FIFO (including after reset) reads zero.
    dout         = dout_valid ? mem[rd_ptr] : '0;
    busy         = (state != IDLE);
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      stop_bad <= 1'b0;
      par_bad  <= 1'b0;
      shreg    <= '0;
    end else if (!en) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= START;
            cnt   <= HALF_BIT;
          end
        end
        START: begin
          if (tick) begin
            if (!rx_sync) begin
              state    <= DATA;
              cnt      <= FULL_BIT;
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              stop_bad <= 1'b0;
              par_bad  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            cnt     <= FULL_BIT;
            if (bit_idx == LAST_DATA) state <= (PARITY != 0) ? PAR : STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PAR: begin
          if (tick) begin
            par_bad <= ((^shreg) ^ rx_sync) != ODD;
            cnt     <= FULL_BIT;
            state   <= STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_idx == LAST_STOP) begin
              state <= IDLE;
            end else begin
              stop_idx <= stop_idx + 1'b1;
              stop_bad <= stop_now_bad;
              cnt      <= FULL_BIT;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      brk        <= 1'b0;
    end else begin
      parity_err <= (parity_err & ~clr_err) | pe_evt;
      frame_err  <= (frame_err  & ~clr_err) | fe_evt;
      overrun    <= (overrun    & ~clr_err) | ov_evt;
      brk        <= (brk        & ~clr_err) | brk_evt;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: one 8N1 receiver with a 4-deep FIFO and
// one 8E2 receiver, both at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic Rst;
  always #5 clk = ~clk;

  logic       rx_a, en_a, clr_a, rdy_a;
  logic [7:0] dout_a;
  logic       valid_a, pe_a, fe_a, ov_a, brk_a, busy_a;
  logic [2:0] cnt_a;

  logic       rx_b, en_b, clr_b, rdy_b;
  logic [7:0] dout_b;
  logic       valid_b, pe_b, fe_b, ov_b, brk_b, busy_b;
  logic [2:0] cnt_b;

  int checks = 0;
  int failures = 0;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .Rst(Rst), .rx(rx_a), .en(en_a), .clr_err(clr_a),
    .dout(dout_a), .dout_valid(valid_a), .dout_ready(rdy_a), .fifo_count(cnt_a),
    .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a), .brk(brk_a), .busy(busy_a));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .Rst(Rst), .rx(rx_b), .en(en_b), .clr_err(clr_b),
    .dout(dout_b), .dout_valid(valid_b), .dout_ready(rdy_b), .fifo_count(cnt_b),
    .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b), .brk(brk_b), .busy(busy_b));

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic [1:0] stops;   // [0] is the first stop bit on the line
    logic       push;
    logic       pe;
    logic       fe;
    logic       brk;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input int sel, input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rx_a = bits[i];
      else          rx_b = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic frame_a(input logic [7:0] d);
    send_bits(0, {3'b111, d, 1'b0}, 10);
    rx_a = 1'b1;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_a;
    rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
  endtask

  task automatic pulse_clr_a;
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h07, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'hA5, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h3C, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{8'h00, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};

    Rst = 1'b0;
    rx_a = 1'b1; en_a = 1'b1; clr_a = 1'b0; rdy_a = 1'b0;
    rx_b = 1'b1; en_b = 1'b1; clr_b = 1'b0; rdy_b = 1'b0;
    gap(3);
    check("rst_count", cnt_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_dout", dout_a, 0);
    check("rst_flags", {pe_a, fe_a, ov_a, brk_a}, 0);
    check("rst_busy", busy_a, 0);
    Rst = 1'b1;
    gap(4);

    // 0x55 frame, LSB first
    frame_a(8'h55);
    gap(2);
    check("f55_count", cnt_a, 1);
    check("f55_valid", valid_a, 1);
    check("f55_dout", dout_a, 8'h55);
    check("f55_flags", {pe_a, fe_a, ov_a, brk_a}, 0);
    check("f55_busy", busy_a, 0);
    pop_a();
    check("f55_popped", cnt_a, 0);
    gap(CPB);

    // short low glitch on the line
    rx_a = 1'b0;
    gap(3);
    rx_a = 1'b1;
    gap(2);
    check("glitch_busy_start", busy_a, 1);
    gap(2 * CPB);
    check("glitch_busy_end", busy_a, 0);
    check("glitch_count", cnt_a, 0);
    check("glitch_flags", {pe_a, fe_a, ov_a, brk_a}, 0);

    // line held low for 12 bit times
    send_bits(0, 12'h000, 12);
    rx_a = 1'b1;
    gap(4);
    check("break_count", cnt_a, 0);
    check("break_fe", fe_a, 1);
    check("break_brk", brk_a, 1);
    pulse_clr_a();
    check("break_clr", {fe_a, brk_a}, 0);
    gap(CPB);

    // back-to-back frames without idle time
    send_bits(0, {3'b111, 8'h12, 1'b0}, 10);
    frame_a(8'h34);
    gap(2);
    check("b2b_count", cnt_a, 2);
    check("b2b_head0", dout_a, 8'h12);
    pop_a();
    check("b2b_head1", dout_a, 8'h34);
    pop_a();
    check("b2b_flags", {fe_a, brk_a}, 0);
    gap(CPB);

    // enable drop mid-frame abandons it
    fork
      frame_a(8'h0F);
      begin
        gap(59);
        check("en_busy_before", busy_a, 1);
        en_a = 1'b0;
        @(negedge clk);
        check("en_busy_after", busy_a, 0);
      end
    join
    gap(8);
    en_a = 1'b1;
    gap(4);
    check("en_count", cnt_a, 0);
    check("en_busy_idle", busy_a, 0);

    // overrun: 5 frames into a 4-deep FIFO with no consumer
    for (int i = 1; i <= 5; i++) begin
      frame_a(8'(i));
      gap(8);
    end
    check("ovr_count", cnt_a, 4);
    check("ovr_flag", ov_a, 1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovr_pop%0d", i), dout_a, i);
      pop_a();
    end
    check("ovr_empty", valid_a, 0);
    pulse_clr_a();
    check("ovr_clr", ov_a, 0);

    // full FIFO with a pop on the exact push edge of the 5th frame
    for (int i = 1; i <= 4; i++) begin
      frame_a(8'(i));
      gap(8);
    end
    check("full_count", cnt_a, 4);
    fork
      frame_a(8'h05);
      begin
        gap(154);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
      end
    join
    gap(4);
    check("simul_count", cnt_a, 4);
    check("simul_ovr", ov_a, 0);
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("simul_pop%0d", i), dout_a, i);
      pop_a();
    end
    check("simul_empty", cnt_a, 0);
    gap(CPB);

    // table-driven frames on the even-parity, 2-stop receiver
    for (int i = 0; i < 9; i++) begin
      clr_b = 1'b1;
      @(negedge clk);
      clr_b = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_pre_flags", i), {pe_b, fe_b, brk_b}, 0);
      send_bits(1, {vecs[i].stops[1], vecs[i].stops[0], vecs[i].par, vecs[i].data, 1'b0}, 12);
      rx_b = 1'b1;
      gap(4);
      check($sformatf("v%0d_count", i), cnt_b, {2'b00, vecs[i].push});
      if (vecs[i].push) check($sformatf("v%0d_dout", i), dout_b, vecs[i].data);
      check($sformatf("v%0d_pe", i), pe_b, vecs[i].pe);
      check($sformatf("v%0d_fe", i), fe_b, vecs[i].fe);
      check($sformatf("v%0d_brk", i), brk_b, vecs[i].brk);
      if (vecs[i].push) begin
        rdy_b = 1'b1;
        @(negedge clk);
        rdy_b = 1'b0;
      end
      gap(2 * CPB);
      check($sformatf("v%0d_empty", i), cnt_b, 0);
    end

    // reset in the middle of data bit 3 of 0xA3
    frame_a(8'h5A);
    gap(8);
    send_bits(0, 12'h000, 12);
    rx_a = 1'b1;
    gap(8);
    check("prerst_count", cnt_a, 1);
    check("prerst_fe", fe_a, 1);
    send_bits(0, {3'b111, 8'hA3, 1'b0}, 4);
    rx_a = 1'b0;
    gap(8);
    check("prerst_busy", busy_a, 1);
    #2;
    Rst = 1'b0;
    #1;
    check("midrst_count", cnt_a, 0);
    check("midrst_valid", valid_a, 0);
    check("midrst_dout", dout_a, 0);
    check("midrst_flags", {pe_a, fe_a, ov_a, brk_a}, 0);
    check("midrst_busy", busy_a, 0);
    rx_a = 1'b1;
    @(negedge clk);
    Rst = 1'b1;
    gap(2 * CPB);
    check("postrst_busy", busy_a, 0);
    check("postrst_count", cnt_a, 0);
    frame_a(8'hA3);
    gap(2);
    check("postrst_count1", cnt_a, 1);
    check("postrst_dout", dout_a, 8'hA3);
    check("postrst_flags", {pe_a, fe_a, ov_a, brk_a}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
